// File: rtl/enc_event_queue.sv
// Encoder event queue: detects rising edges on per-encoder event flags, latches
// the accompanying codes, picks one pending channel per cycle round-robin and
// buffers the codes in a FIFO that the host drains through a valid/ack port.
module enc_event_queue #(
    parameter int N_ENC  = 4,
    parameter int CODE_W = 6,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_ENC-1:0]        ev_flag,
    input  logic [N_ENC*CODE_W-1:0] ev_code,
    output logic [CODE_W-1:0]       code_out,
    output logic                    code_valid,
    input  logic                    code_ack,
    output logic                    irq,
    output logic [ADDR_W:0]         fifo_count,
    output logic                    ovf,
    input  logic                    ovf_clr
);

    localparam int IDX_W = (N_ENC > 1) ? $clog2(N_ENC) : 1;

    logic [N_ENC-1:0]  flagD_r;
    logic [N_ENC-1:0]  pending_r;
    logic [CODE_W-1:0] lcode_r [N_ENC];
    logic [CODE_W-1:0] mem_r [DEPTH];
    logic [ADDR_W:0]   wrPtr_r;
    logic [ADDR_W:0]   rdPtr_r;
    logic [ADDR_W:0]   count_r;
    logic [IDX_W-1:0]  rrPtr_r;
    logic [CODE_W-1:0] codeOut_r;
    logic              codeValid_r;
    logic              ovf_r;

    logic [N_ENC-1:0]  rise_s;
    logic [N_ENC-1:0]  pendingNext_s;
    logic [N_ENC-1:0]  lcodeLoad_s;
    logic [N_ENC-1:0]  dropVec_s;
    logic [IDX_W-1:0]  cand_s;
    logic              candValid_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic [CODE_W-1:0] pushCode_s;
    logic [ADDR_W:0]   rdPtrNext_s;
    logic [ADDR_W:0]   countNext_s;
    logic [CODE_W-1:0] headNext_s;

    assign rise_s     = ev_flag & ~flagD_r;
    // Full when the wrap bits differ and the slot addresses coincide.
    assign full_s     = (wrPtr_r[ADDR_W] != rdPtr_r[ADDR_W]) &&
                        (wrPtr_r[ADDR_W-1:0] == rdPtr_r[ADDR_W-1:0]);
    assign pop_s      = code_ack & codeValid_r;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_s     = candValid_s & (~full_s | pop_s);
    assign pushCode_s = lcode_r[cand_s];

    // Round-robin search of pending bits starting at the pointer, wrapping modulo N_ENC.
    always_comb begin
        int idx;
        candValid_s = 1'b0;
        cand_s      = '0;
        idx         = 0;
        for (int k = 0; k < N_ENC; k++) begin
            idx = int'(rrPtr_r) + k;
            if (idx >= N_ENC) begin
                idx = idx - N_ENC;
            end else begin
                idx = idx;
            end
            if (!candValid_s && pending_r[IDX_W'(idx)]) begin
                candValid_s = 1'b1;
                cand_s      = IDX_W'(idx);
            end else begin
                candValid_s = candValid_s;
            end
        end
    end

    // Per-channel capture: new edge latches when free (or freed by this cycle's push), else is dropped.
    always_comb begin
        pendingNext_s = pending_r;
        lcodeLoad_s   = '0;
        dropVec_s     = '0;
        for (int i = 0; i < N_ENC; i++) begin
            if (rise_s[i] && (!pending_r[i] || (push_s && (cand_s == IDX_W'(i))))) begin
                pendingNext_s[i] = 1'b1;
                lcodeLoad_s[i]   = 1'b1;
            end else if (rise_s[i]) begin
                dropVec_s[i]     = 1'b1;
            end else if (push_s && (cand_s == IDX_W'(i))) begin
                pendingNext_s[i] = 1'b0;
            end else begin
                pendingNext_s[i] = pending_r[i];
            end
        end
    end

    // Next read pointer, occupancy and head value; a push into the next head slot bypasses the array.
    always_comb begin
        rdPtrNext_s = rdPtr_r + {{ADDR_W{1'b0}}, pop_s};
        case ({push_s, pop_s})
            2'b10:   countNext_s = count_r + {{ADDR_W{1'b0}}, 1'b1};
            2'b01:   countNext_s = count_r - {{ADDR_W{1'b0}}, 1'b1};
            default: countNext_s = count_r;
        endcase
        if (push_s && (wrPtr_r == rdPtrNext_s)) begin
            headNext_s = pushCode_s;
        end else begin
            headNext_s = mem_r[rdPtrNext_s[ADDR_W-1:0]];
        end
    end

    // FIFO storage write; contents need no reset because occupancy gates their use.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wrPtr_r[ADDR_W-1:0]] <= pushCode_s;
        end
    end

    // Control state: edge history, pending/latched codes, pointers, registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            flagD_r     <= '0;
            pending_r   <= '0;
            for (int i = 0; i < N_ENC; i++) begin
                lcode_r[i] <= '0;
            end
            wrPtr_r     <= '0;
            rdPtr_r     <= '0;
            count_r     <= '0;
            rrPtr_r     <= '0;
            codeOut_r   <= '0;
            codeValid_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            flagD_r   <= ev_flag;
            pending_r <= pendingNext_s;
            for (int i = 0; i < N_ENC; i++) begin
                if (lcodeLoad_s[i]) begin
                    lcode_r[i] <= ev_code[i*CODE_W +: CODE_W];
                end
            end
            if (push_s) begin
                wrPtr_r <= wrPtr_r + {{ADDR_W{1'b0}}, 1'b1};
                if (cand_s == IDX_W'(N_ENC - 1)) begin
                    rrPtr_r <= '0;
                end else begin
                    rrPtr_r <= cand_s + IDX_W'(1);
                end
            end
            rdPtr_r     <= rdPtrNext_s;
            count_r     <= countNext_s;
            codeOut_r   <= headNext_s;
            codeValid_r <= (countNext_s != '0);
            // A drop in the same cycle as a clear request keeps the flag set.
            if (|dropVec_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

    assign code_out   = codeOut_r;
    assign code_valid = codeValid_r;
    assign irq        = codeValid_r;
    assign fifo_count = count_r;
    assign ovf        = ovf_r;

endmodule

// File: doc/enc_event_queue.md
Name: enc_event_queue

Overview:
Collects rotation events from N_ENC encoder readers and queues their 6-bit event codes in a FIFO for the host MCU interface. It sits directly downstream of the per-encoder readers, which each present a level event flag and a direction-resolved code. The block detects flag rising edges, latches the codes, arbitrates round-robin between encoders and buffers the codes. Codes are presented on a valid/ack pop port, with an interrupt request while the queue is non-empty.

Parameters:
N_ENC, 4, number of encoder channels (1..8)
CODE_W, 6, event code width
DEPTH, 8, FIFO depth in entries; power of two, 2..16
ADDR_W, 3, log2(DEPTH)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ev_flag  in  N_ENC  per-encoder event level (bit i = encoder i); synchronous to clk
ev_code  in  N_ENC*CODE_W  per-encoder code; channel i occupies bits [i*CODE_W +: CODE_W]
code_out  out  CODE_W  head-of-queue code
code_valid  out  1  queue non-empty, code_out valid
code_ack  in  1  pop head; effective only while code_valid=1
irq  out  1  interrupt request to host; equals code_valid
fifo_count  out  ADDR_W+1  number of entries in the queue, 0..DEPTH
ovf  out  1  sticky event-lost flag
ovf_clr  in  1  clears ovf

Behaviour:
- Reset (rst=1 at a clock edge): code_out=0, code_valid=0, irq=0, fifo_count=0, ovf=0. Also clears all pending bits, the edge-detect history, the latched codes, the FIFO pointers and the round-robin pointer (next candidate = channel 0). Reset mid-operation discards all queued and pending events.
- Edge detect: flag_d[i] is a register of ev_flag[i]. A rising edge on channel i is ev_flag[i]=1 and flag_d[i]=0.
- Capture on a rising edge on channel i:
  - pending[i]=0: pending[i]<=1 and lcode[i]<=ev_code slice i. The code is sampled in the same cycle as the edge.
  - pending[i]=1: the new event is dropped, lcode[i] is kept, and ovf<=1.
  - A flag held high produces exactly one event.
- Arbiter: each cycle, search the pending bits starting at the round-robin pointer and wrapping modulo N_ENC. The first set bit is the candidate.
- Push: a candidate is pushed when the FIFO is not full, or when it is full and a pop is effective in the same cycle. On push:
  - lcode[candidate] is written at wr_ptr and wr_ptr increments.
  - pending[candidate]<=0.
  - the round-robin pointer becomes candidate+1, wrapping to 0 after N_ENC-1.
  - At most one push per cycle.
- Clear vs. set, same cycle: a pending bit cleared by a push and set by a new rising edge on the same channel in the same cycle ends set, with the new code latched. This case is not an overflow.
- Full FIFO: pending bits wait, with no loss, until space frees.
- Latency: a rising edge sampled at edge T sets pending at T. The push occurs at T+1 if the FIFO has room and no higher-priority candidate exists. code_valid=1 after T+1 when the queue was empty.
- Pop: when code_ack=1 and code_valid=1, rd_ptr increments and the next entry appears the following cycle. code_ack while empty is ignored, with no pointer movement.
- code_out is the registered or array-read value at rd_ptr and is stable while code_valid=1 and no pop occurs.
- fifo_count: +1 on push only, -1 on pop only, unchanged on push+pop. Never exceeds DEPTH and never goes below 0.
- Pointer wrap: pointers are ADDR_W+1 bits and wrap naturally. Full is when the MSBs differ and the low bits are equal.
- ovf:
  - set by any dropped event.
  - cleared by ovf_clr.
  - if ovf_clr and a drop occur in the same cycle, set wins.
- irq = code_valid, level-sensitive.

Test Plan:
- Single event: reset, ev_code[5:0]=6'h10, pulse ev_flag[0] high for 5 cycles. Required: code_valid rises 2 cycles after the flag edge, code_out=6'h10, fifo_count=1. ack -> code_valid=0, fifo_count=0. Only one entry is queued.
- Simultaneous events: ev_flag=4'b1111 rise in one cycle, codes 6'h02/6'h04/6'h06/6'h08. Required: the FIFO receives 02,04,06,08 on consecutive cycles, round-robin from ptr=0. A further event on channel 0 then channel 1 while the pointer is at 0 yields channel 0 first.
- Fill/full: 8 events, no ack -> fifo_count=8. A 9th event on channel 2 stays pending with no loss. One ack -> the channel 2 code enters in the same cycle and fifo_count stays 8. Draining 9 codes returns them in push order.
- Overflow: with the FIFO full and channel 1 pending, a second channel 1 rising edge -> ovf=1 and the original code is retained. ovf_clr=1 -> ovf=0. ovf_clr coincident with a new drop -> ovf stays 1.
- Pop on empty and wrap: code_ack with the queue empty -> fifo_count stays 0 and pointers do not move. Push/pop 20 events alternately -> order is preserved across pointer wrap.
- Reset mid-operation: fifo_count=5 and 2 pending, assert rst one cycle. Required: all outputs 0, and the next single event is output alone.
